instr_mem_fetch: RTL and testbench
==================================

# instr_mem_fetch

Parametrised instruction memory for the custom processor, succeeding the fixed 8-bit × 4-word instruction memory. Adds a program-load write port, a valid/ready fetch request/response handshake with one-cycle registered read and backpressure, out-of-range address detection, and a saturating fetch counter. It sits between the processor's fetch stage (PC side) and the program loader used by testbenches and the boot path.

## Interface
- WIDTH, 8, instruction word width in bits (≥1)
- DEPTH, 16, number of instruction words (≥2; need not be a power of two)
- AW, $clog2(DEPTH), address width (derived; not overridden)
- CNT_W, 16, width of the fetch counter

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ld_en  in  1  program-load write enable
- ld_addr  in  AW  program-load word address
- ld_data  in  WIDTH  program-load word
- req_valid  in  1  fetch request valid
- req_addr  in  AW  fetch word address
- req_ready  out  1  fetch request accepted this cycle when high with req_valid
- resp_valid  out  1  response word valid
- resp_data  out  WIDTH  fetched instruction
- resp_err  out  1  response address was ≥ DEPTH; qualifies resp_valid
- resp_ready  in  1  consumer accepts response
- fetch_cnt  out  CNT_W  number of accepted fetches, saturating

## Operation
- Storage: DEPTH × WIDTH array. Contents are not cleared by rst; power-up contents all zero (initialised at declaration).
- Load: ld_en=1 with ld_addr < DEPTH writes ld_data at the rising edge. ld_addr ≥ DEPTH is ignored (no write, no flag). Load works regardless of fetch state and during rst.
- Fetch accept: req_ready = !resp_valid || resp_ready (combinational). A fetch is accepted when req_valid && req_ready.
- On accept: next cycle resp_valid=1, resp_data=mem[req_addr], resp_err=0; if req_addr ≥ DEPTH then resp_data=0, resp_err=1.
- Response hold: while resp_valid=1 and resp_ready=0, resp_data/resp_err are held stable and req_ready=0.
- Response retire: resp_valid && resp_ready with no new accept → resp_valid=0 next cycle; with a new accept in the same cycle → new response next cycle (back-to-back, full throughput one word/cycle).
- Read/write collision: load and accepted fetch to the same address in the same cycle → response carries the OLD word (read-first); the new word is visible to fetches accepted from the next cycle.
- fetch_cnt increments by 1 per accepted fetch (including out-of-range ones); saturates at 2^CNT_W−1, never wraps.
- resp_data is 0 whenever resp_valid=0 is the result of reset; after a retire, resp_data keeps its last value (don't-care to consumers).

## Timing
- Read latency: 1 cycle from accepting edge to resp_valid.
- Reset (rst=1 at an edge): resp_valid=0, resp_data=0, resp_err=0, fetch_cnt=0. req_ready is 1 in the cycle after reset since resp_valid=0; requests presented while rst=1 are not accepted (req_ready forced 0 during rst).
- Reset mid-operation: a pending unaccepted response is discarded; an in-flight accept in the same cycle as rst is dropped and not counted.
- No combinational path from resp_ready to resp_data; only req_ready depends combinationally on resp_ready.

## Test plan
- Reset/defaults: assert rst 2 cycles → resp_valid=0, resp_data=0x00, resp_err=0, fetch_cnt=0, req_ready=0 during rst, 1 after.
- Load then stream: load 0x11,0x22,0x33,0x44 at addrs 0–3; request 0,1,2,3 on consecutive cycles with resp_ready=1 → responses 0x11..0x44 one cycle after each request, no bubbles, fetch_cnt=4.
- Backpressure: request addr 2, hold resp_ready=0 for 3 cycles → resp_data=0x33 stable, req_ready=0; release → retired, next request accepted same cycle.
- Collision: mem[1]=0x22; same cycle ld_en addr1 data 0xAB and fetch addr1 → response 0x22; next fetch addr1 → 0xAB.
- Out-of-range: DEPTH=5, fetch addr 6 → resp_valid=1, resp_err=1, resp_data=0; load to addr 7 leaves memory unchanged.
- Counter saturation and reset mid-op: CNT_W=3, 9 accepted fetches → fetch_cnt=7; assert rst with resp_valid=1 pending → resp_valid=0, fetch_cnt=0 next cycle, memory contents retained (fetch addr0 returns 0x11).

Source files
------------

// File: rtl/instr_mem_fetch.sv
// Parametrised instruction memory with program-load port, one-cycle registered
// fetch response under valid/ready backpressure, and a saturating fetch counter.
module instr_mem_fetch #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             req_valid,
  input  logic [AW-1:0]    req_addr,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  input  logic             resp_ready,
  output logic [CNT_W-1:0] fetch_cnt
);

  // Storage survives rst; only power-up clears it.
  logic [WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_data_q,  resp_data_d;
  logic             resp_err_q,   resp_err_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;

  logic ld_in_range, req_in_range, accept;

  // Zero-extend before comparing so non power-of-two depths are handled.
  assign ld_in_range  = ({{(32-AW){1'b0}}, ld_addr}  < 32'(DEPTH));
  assign req_in_range = ({{(32-AW){1'b0}}, req_addr} < 32'(DEPTH));

  assign req_ready = !rst && (!resp_valid_q || resp_ready);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (ld_en && ld_in_range) mem_q[ld_addr] <= ld_data;
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    cnt_d        = cnt_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_data_d  = req_in_range ? mem_q[req_addr] : '0;
      resp_err_d   = !req_in_range;
      cnt_d        = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end else if (resp_ready) begin
      // Retired word stays on resp_data; consumers ignore it without resp_valid.
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Bench for instr_mem_fetch: directed test-plan sequences plus random traffic,
// all checked against a cycle-level behavioural model of the memory.
module tb_instr_mem_fetch;
  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, ld_en, req_valid, resp_ready;
  logic [AW-1:0]    ld_addr, req_addr;
  logic [WIDTH-1:0] ld_data;
  logic             req_ready, resp_valid, resp_err;
  logic [WIDTH-1:0] resp_data;
  logic [CNT_W-1:0] fetch_cnt;

  instr_mem_fetch #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .resp_ready(resp_ready), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int        m_mem [DEPTH];
  bit        m_valid;
  int        m_data;
  bit        m_err;
  int        m_cnt;

  task automatic cyc(input bit r, input bit le, input int la, input int ld,
                     input bit rv, input int ra, input bit rr);
    bit m_ready, acc;
    @(negedge clk);
    rst = r; ld_en = le; ld_addr = AW'(la); ld_data = WIDTH'(ld);
    req_valid = rv; req_addr = AW'(ra); resp_ready = rr;
    m_ready = !r && (!m_valid || rr);
    acc = rv && m_ready;
    #1 chk("req_ready", req_ready, m_ready);
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_data = 0; m_err = 0; m_cnt = 0;
    end else if (acc) begin
      m_valid = 1;
      if (ra < DEPTH) begin m_data = m_mem[ra]; m_err = 0; end
      else            begin m_data = 0;         m_err = 1; end
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    end else if (rr) begin
      m_valid = 0;
    end
    if (le && la < DEPTH) m_mem[la] = ld;
    #1;
    chk("resp_valid", resp_valid, m_valid);
    chk("resp_data",  resp_data,  m_data);
    chk("resp_err",   resp_err,   m_err);
    chk("fetch_cnt",  fetch_cnt,  m_cnt);
  endtask

  initial begin
    foreach (m_mem[i]) m_mem[i] = 0;
    m_valid = 0; m_data = 0; m_err = 0; m_cnt = 0;
    rst = 1; ld_en = 0; ld_addr = '0; ld_data = '0;
    req_valid = 0; req_addr = '0; resp_ready = 0;

    // Reset / defaults (requests during reset must be ignored)
    cyc(1, 0, 0, 0, 1, 0, 1);
    cyc(1, 0, 0, 0, 1, 0, 1);
    chk("rst_valid", resp_valid, 0);
    chk("rst_data",  resp_data,  0);
    chk("rst_cnt",   fetch_cnt,  0);
    @(negedge clk); rst = 0; req_valid = 0;
    #1 chk("ready_after_rst", req_ready, 1);

    // Load then stream
    cyc(0, 1, 0, 8'h11, 0, 0, 1);
    cyc(0, 1, 1, 8'h22, 0, 0, 1);
    cyc(0, 1, 2, 8'h33, 0, 0, 1);
    cyc(0, 1, 3, 8'h44, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1, i, 1);
      chk("stream_data", resp_data, 32'h11 * (i + 1));
    end
    chk("stream_cnt", fetch_cnt, 4);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("stream_retire", resp_valid, 0);

    // Backpressure
    cyc(0, 0, 0, 0, 1, 2, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 3, 0);
      chk("bp_hold", resp_data, 8'h33);
    end
    cyc(0, 0, 0, 0, 1, 3, 1);
    chk("bp_next", resp_data, 8'h44);

    // Read/write collision: old word first, new word afterwards
    cyc(0, 1, 1, 8'hAB, 1, 1, 1);
    chk("coll_old", resp_data, 8'h22);
    cyc(0, 0, 0, 0, 1, 1, 1);
    chk("coll_new", resp_data, 8'hAB);
    chk("cnt_sat", fetch_cnt, 7);

    // Out-of-range fetch and ignored out-of-range load
    cyc(0, 1, 7, 8'h55, 1, 6, 1);
    chk("oor_err",  resp_err,  1);
    chk("oor_data", resp_data, 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 1, i, 1);
    chk("cnt_still_sat", fetch_cnt, 7);

    // Reset with a pending response and a concurrent request
    cyc(0, 0, 0, 0, 1, 2, 0);
    cyc(1, 0, 0, 0, 1, 3, 0);
    chk("midrst_valid", resp_valid, 0);
    chk("midrst_cnt",   fetch_cnt,  0);
    cyc(0, 0, 0, 0, 1, 0, 1);
    chk("retained", resp_data, 8'h11);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 2) == 0,
          $urandom_range(0, (1 << AW) - 1), $urandom_range(0, 255),
          $urandom_range(0, 3) != 0, $urandom_range(0, (1 << AW) - 1),
          $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
